// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - RV32I memory-stage data-bus access controller
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [1:0]  mem_storeM,
    input  logic [2:0]  mem_loadM,
    input  logic [31:0] resultM,
    input  logic [31:0] store_dataM,
    output logic        stallM,
    output logic [31:0] load_dataM,
    output logic        err,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [31:0] dreq_addr,
    output logic        dreq_we,
    output logic [3:0]  dreq_be,
    output logic [31:0] dreq_wdata,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYC - 1) : 16'd0;

    state_t      r_state;
    logic [2:0]  r_ld_op;
    logic [1:0]  r_a;
    logic [15:0] r_cnt;
    logic        r_valid;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic [3:0]  r_be;

    logic        w_is_store;
    logic        w_is_load;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_trap;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic        w_timeout;
    logic [15:0] w_cnt_next;

    // Access size: 0 byte, 1 half, 2 word. A store always takes priority over a load.
    always_comb begin
        w_is_store = (mem_storeM != 2'd0);
        w_is_load  = (mem_loadM >= 3'd1) && (mem_loadM <= 3'd5);
        w_size     = 2'd2;
        if (w_is_store) begin
            w_size = mem_storeM - 2'd1;
        end else begin
            case (mem_loadM)
                3'd1, 3'd4: w_size = 2'd0;
                3'd2, 3'd5: w_size = 2'd1;
                default:    w_size = 2'd2;
            endcase
        end

        w_be = 4'b1111;
        case (w_size)
            2'd0:    w_be = 4'b0001 << resultM[1:0];
            2'd1:    w_be = resultM[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase

        w_wdata = 32'd0;
        case (mem_storeM)
            2'd1:    w_wdata = {4{store_dataM[7:0]}};
            2'd2:    w_wdata = {2{store_dataM[15:0]}};
            2'd3:    w_wdata = store_dataM;
            default: w_wdata = 32'd0;
        endcase

`ifdef DMEM_MISALIGN_TRAP_EN
        w_trap = ((w_size == 2'd1) && resultM[0]) ||
                 ((w_size == 2'd2) && (resultM[1:0] != 2'b00));
`else
        w_trap = 1'b0;
`endif
    end

    always_comb begin
        w_byte = 8'd0;
        case (r_a)
            2'd0: w_byte = drsp_rdata[7:0];
            2'd1: w_byte = drsp_rdata[15:8];
            2'd2: w_byte = drsp_rdata[23:16];
            2'd3: w_byte = drsp_rdata[31:24];
            default: w_byte = 8'd0;
        endcase
        w_half = r_a[1] ? drsp_rdata[31:16] : drsp_rdata[15:0];

        w_fmt = 32'd0;
        case (r_ld_op)
            3'd1:    w_fmt = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_fmt = {{16{w_half[15]}}, w_half};
            3'd3:    w_fmt = drsp_rdata;
            3'd4:    w_fmt = {24'd0, w_byte};
            3'd5:    w_fmt = {16'd0, w_half};
            default: w_fmt = 32'd0;
        endcase

        // Counter saturates so a disabled timeout can never wrap into a false hit.
        w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        w_timeout  = TO_EN && (r_cnt >= TO_LAST);
    end

    assign stallM     = (w_is_store || w_is_load) && (r_state != S_DONE);
    assign load_dataM = r_load_data;
    assign err        = r_err;
    assign dreq_valid = r_valid;
    assign dreq_addr  = r_addr;
    assign dreq_we    = r_we;
    assign dreq_be    = r_be;
    assign dreq_wdata = r_wdata;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_state     <= S_IDLE;
            r_ld_op     <= 3'd0;
            r_a         <= 2'd0;
            r_cnt       <= 16'd0;
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
            r_be        <= 4'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_load_data <= 32'd0;
                    if (w_is_store || w_is_load) begin
                        r_ld_op <= w_is_store ? 3'd0 : mem_loadM;
                        r_a     <= resultM[1:0];
                        if (w_trap) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_valid <= 1'b1;
                            r_addr  <= {resultM[31:2], 2'b00};
                            r_we    <= w_is_store;
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_cnt   <= 16'd0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (dreq_ready) begin
                        r_valid <= 1'b0;
                        r_state <= r_we ? S_DONE : S_RSP;
                    end else if (w_timeout) begin
                        r_valid     <= 1'b0;
                        r_err       <= 1'b1;
                        r_load_data <= 32'd0;
                        r_state     <= S_DONE;
                    end
                end
                S_RSP: begin
                    r_cnt <= w_cnt_next;
                    if (drsp_valid) begin
                        r_load_data <= w_fmt;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_load_data <= 32'd0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_load_data <= 32'd0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed table-driven bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic        CLK = 1'b0;
    logic        NRST;
    logic [1:0]  mem_storeM;
    logic [2:0]  mem_loadM;
    logic [31:0] resultM;
    logic [31:0] store_dataM;
    logic        stallM;
    logic [31:0] load_dataM;
    logic        err;
    logic        dreq_valid;
    logic        dreq_ready;
    logic [31:0] dreq_addr;
    logic        dreq_we;
    logic [3:0]  dreq_be;
    logic [31:0] dreq_wdata;
    logic        drsp_valid;
    logic [31:0] drsp_rdata;

    int n_pass = 0;
    int n_total = 0;
    int hs_cnt = 0;

    mem_stage_ctrl #(.TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .NRST(NRST), .mem_storeM(mem_storeM), .mem_loadM(mem_loadM),
        .resultM(resultM), .store_dataM(store_dataM), .stallM(stallM),
        .load_dataM(load_dataM), .err(err), .dreq_valid(dreq_valid),
        .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_we(dreq_we),
        .dreq_be(dreq_be), .dreq_wdata(dreq_wdata), .drsp_valid(drsp_valid),
        .drsp_rdata(drsp_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (NRST && dreq_valid && dreq_ready) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ldata;
        int          stalls;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at negedge+1 with the FSM in IDLE; returns at negedge+1 back in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int  stalls;
        bit  seen;
        mem_storeM  = v.st;
        mem_loadM   = v.ld;
        resultM     = v.addr;
        store_dataM = v.sdata;
        drsp_rdata  = v.rdata;
        dreq_ready  = 1'b1;
        drsp_valid  = 1'b1;
        stalls = 0;
        seen   = 0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (!stallM) break;
            stalls++;
            if (dreq_valid && !seen) begin
                seen = 1;
                chk($sformatf("v%0d_addr", idx), dreq_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_be", idx), {28'd0, dreq_be}, {28'd0, v.be});
                chk($sformatf("v%0d_we", idx), {31'd0, dreq_we}, {31'd0, v.we});
                if (v.we) chk($sformatf("v%0d_wdata", idx), dreq_wdata, v.wdata);
            end
            @(negedge CLK);
            #1;
        end
        chk($sformatf("v%0d_req_seen", idx), {31'd0, seen}, 32'd1);
        chk($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.stalls));
        chk($sformatf("v%0d_ldata", idx), load_dataM, v.ldata);
        chk($sformatf("v%0d_err", idx), {31'd0, err}, 32'd0);
        chk($sformatf("v%0d_done_valid", idx), {31'd0, dreq_valid}, 32'd0);
        mem_storeM = 2'd0;
        mem_loadM  = 3'd0;
        drsp_valid = 1'b0;
        @(negedge CLK);
        #1;
        chk($sformatf("v%0d_ldata_clr", idx), load_dataM, 32'd0);
    endtask

    initial begin
        int   hs0;
        int   k;
        vec_t v;

        vecs[0]  = '{2'd1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 4'b1000, 1'b1, 32'hABAB_ABAB, 32'h0, 2};
        vecs[1]  = '{2'd2, 3'd0, 32'h0000_1006, 32'h1234_BEEF, 32'h0, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0, 2};
        vecs[2]  = '{2'd3, 3'd0, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0, 2};
        vecs[3]  = '{2'd1, 3'd0, 32'h0000_1000, 32'h7766_5555, 32'h0, 4'b0001, 1'b1, 32'h5555_5555, 32'h0, 2};
        vecs[4]  = '{2'd0, 3'd1, 32'h0000_2001, 32'h0, 32'h0000_F000, 4'b0010, 1'b0, 32'h0, 32'hFFFF_FFF0, 3};
        vecs[5]  = '{2'd0, 3'd4, 32'h0000_2001, 32'h0, 32'h0000_F000, 4'b0010, 1'b0, 32'h0, 32'h0000_00F0, 3};
        vecs[6]  = '{2'd0, 3'd2, 32'h0000_2002, 32'h0, 32'h8000_0000, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8000, 3};
        vecs[7]  = '{2'd0, 3'd5, 32'h0000_2000, 32'h0, 32'h1234_ABCD, 4'b0011, 1'b0, 32'h0, 32'h0000_ABCD, 3};
        vecs[8]  = '{2'd0, 3'd3, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D, 3};
        vecs[9]  = '{2'd0, 3'd1, 32'h0000_2003, 32'h0, 32'h7F00_0000, 4'b1000, 1'b0, 32'h0, 32'h0000_007F, 3};
        vecs[10] = '{2'd3, 3'd3, 32'h0000_100C, 32'h1122_3344, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h1122_3344, 32'h0, 2};

        NRST = 1'b0;
        mem_storeM = 2'd0;
        mem_loadM = 3'd3;
        resultM = 32'h0000_0040;
        store_dataM = 32'hFFFF_FFFF;
        dreq_ready = 1'b1;
        drsp_valid = 1'b1;
        drsp_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rst_addr", dreq_addr, 32'd0);
        chk("rst_be", {28'd0, dreq_be}, 32'd0);
        chk("rst_we", {31'd0, dreq_we}, 32'd0);
        chk("rst_wdata", dreq_wdata, 32'd0);
        chk("rst_ldata", load_dataM, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        mem_loadM = 3'd0;
        drsp_valid = 1'b0;
        NRST = 1'b1;
        @(negedge CLK);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Load opcode 6 is not an access.
        mem_loadM = 3'd6;
        resultM = 32'h0000_2000;
        #1;
        chk("ld6_stall", {31'd0, stallM}, 32'd0);
        @(negedge CLK);
        #1;
        chk("ld6_valid", {31'd0, dreq_valid}, 32'd0);
        mem_loadM = 3'd0;

        // Misaligned word load.
`ifdef DMEM_MISALIGN_TRAP_EN
        mem_loadM = 3'd3;
        resultM = 32'h0000_3002;
        dreq_ready = 1'b1;
        drsp_valid = 1'b0;
        hs0 = hs_cnt;
        #1;
        chk("mis_stall_n", {31'd0, stallM}, 32'd1);
        @(negedge CLK);
        #1;
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_valid", {31'd0, dreq_valid}, 32'd0);
        chk("mis_stall_n1", {31'd0, stallM}, 32'd0);
        chk("mis_ldata", load_dataM, 32'd0);
        mem_loadM = 3'd0;
        @(negedge CLK);
        #1;
        chk("mis_err_pulse", {31'd0, err}, 32'd0);
        chk("mis_no_hs", 32'(hs_cnt - hs0), 32'd0);
`else
        v = '{2'd0, 3'd3, 32'h0000_3002, 32'h0, 32'h0102_0304, 4'b1111, 1'b0, 32'h0, 32'h0102_0304, 3};
        run_vec(v, 11);
`endif

        // Ready held low for five REQ cycles.
        mem_storeM = 2'd3;
        resultM = 32'h0000_4000;
        store_dataM = 32'hA5A5_A5A5;
        dreq_ready = 1'b0;
        drsp_valid = 1'b0;
        hs0 = hs_cnt;
        @(negedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rl%0d_valid", i), {31'd0, dreq_valid}, 32'd1);
            chk($sformatf("rl%0d_addr", i), dreq_addr, 32'h0000_4000);
            chk($sformatf("rl%0d_be", i), {28'd0, dreq_be}, 32'h0000_000F);
            chk($sformatf("rl%0d_wdata", i), dreq_wdata, 32'hA5A5_A5A5);
            chk($sformatf("rl%0d_stall", i), {31'd0, stallM}, 32'd1);
            @(negedge CLK);
            #1;
        end
        dreq_ready = 1'b1;
        #1;
        chk("rl_last_valid", {31'd0, dreq_valid}, 32'd1);
        @(negedge CLK);
        #1;
        chk("rl_done_stall", {31'd0, stallM}, 32'd0);
        chk("rl_done_valid", {31'd0, dreq_valid}, 32'd0);
        mem_storeM = 2'd0;
        @(negedge CLK);
        #1;
        chk("rl_one_hs", 32'(hs_cnt - hs0), 32'd1);

        // Timeout: load with no response.
        mem_loadM = 3'd3;
        resultM = 32'h0000_5000;
        dreq_ready = 1'b1;
        drsp_valid = 1'b0;
        @(negedge CLK);
        #1;
        k = 0;
        while (err !== 1'b1 && k < 30) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("to_cycles", 32'(k), 32'd8);
        chk("to_ldata", load_dataM, 32'd0);
        chk("to_stall", {31'd0, stallM}, 32'd0);
        mem_loadM = 3'd0;
        @(negedge CLK);
        #1;
        chk("to_err_pulse", {31'd0, err}, 32'd0);
        chk("to_idle_valid", {31'd0, dreq_valid}, 32'd0);

        // Reset while waiting for the response, then a late response.
        mem_loadM = 3'd3;
        resultM = 32'h0000_6000;
        dreq_ready = 1'b1;
        drsp_valid = 1'b0;
        @(negedge CLK);
        #1;
        @(negedge CLK);
        #1;
        chk("rr_in_rsp_stall", {31'd0, stallM}, 32'd1);
        chk("rr_in_rsp_valid", {31'd0, dreq_valid}, 32'd0);
        NRST = 1'b0;
        mem_loadM = 3'd0;
        drsp_valid = 1'b1;
        drsp_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        #1;
        NRST = 1'b1;
        chk("rr_addr", dreq_addr, 32'd0);
        chk("rr_be", {28'd0, dreq_be}, 32'd0);
        @(negedge CLK);
        #1;
        chk("rr_ldata", load_dataM, 32'd0);
        chk("rr_err", {31'd0, err}, 32'd0);
        chk("rr_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rr_stall", {31'd0, stallM}, 32'd0);
        @(negedge CLK);
        #1;
        chk("rr_ldata2", load_dataM, 32'd0);
        drsp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
